// File: rtl/filter_mavg_pkg.sv
// Shared state encoding and width helpers for the multi-channel moving-average filter.
package filter_mavg_pkg;

  typedef enum logic [2:0] {
    StClear = 3'd0,
    StIdle  = 3'd1,
    StRead  = 3'd2,
    StCalc  = 3'd3,
    StOut   = 3'd4
  } state_e;

  function automatic int unsigned calc_ch_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned calc_sum_w(input int unsigned bit_width,
                                             input int unsigned log2_len);
    return bit_width + log2_len;
  endfunction

  function automatic int unsigned calc_adr_w(input int unsigned num_ch,
                                             input int unsigned log2_len);
    return calc_ch_w(num_ch) + log2_len;
  endfunction

endpackage

// File: rtl/mavg_tap_ram.sv
// Simple dual-port tap RAM with registered read; contents are cleared by the filter FSM.
module mavg_tap_ram
  import filter_mavg_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ADR_W = 6,
  parameter int unsigned DEPTH = 64
) (
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [ADR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [ADR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/filter_mavg_multich.sv
// Multi-channel recursive moving average: running sum per channel plus a circular tap buffer,
// one shared add/subtract datapath, one sample per four clocks.
module filter_mavg_multich
  import filter_mavg_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned LOG2_LEN  = 4,
  parameter int unsigned NUM_CH    = 4,
  parameter bit          uint_io   = 1'b0,
  parameter bit          ROUND     = 1'b0,
  localparam int unsigned CH_W     = calc_ch_w(NUM_CH)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 START_FLAG,
  input  logic [CH_W-1:0]      CH_IN,
  input  logic [BIT_WIDTH-1:0] DATA_IN,
  input  logic                 CLR_FLAG,
  output logic [BIT_WIDTH-1:0] DATA_OUT,
  output logic [CH_W-1:0]      CH_OUT,
  output logic                 DATA_VALID,
  output logic                 FILT_RDY,
  output logic [NUM_CH-1:0]    FILLED
);

  localparam int unsigned LENGTH = 2 ** LOG2_LEN;
  localparam int unsigned SUM_W  = calc_sum_w(BIT_WIDTH, LOG2_LEN);
  localparam int unsigned ADR_W  = calc_adr_w(NUM_CH, LOG2_LEN);
  localparam int unsigned DEPTH  = NUM_CH * LENGTH;
  localparam int unsigned FILL_W = LOG2_LEN + 1;
  localparam logic signed [SUM_W:0] RND = ROUND ? (SUM_W + 1)'(LENGTH / 2) : '0;
  localparam logic signed [SUM_W:0] MAX_POS = (SUM_W + 1)'(2 ** (BIT_WIDTH - 1) - 1);

  state_e                       state_q;
  logic [ADR_W-1:0]             clr_cnt_q;
  logic [CH_W-1:0]              ch_q;
  logic signed [BIT_WIDTH-1:0]  data_in0_q;
  logic signed [SUM_W-1:0]      sum_q [NUM_CH];
  logic [LOG2_LEN-1:0]          ptr_q [NUM_CH];
  logic [FILL_W-1:0]            fill_q [NUM_CH];
  logic [BIT_WIDTH-1:0]         data_out_q;
  logic [CH_W-1:0]              ch_out_q;
  logic                         valid_q;
  logic                         rdy_q;

  logic                         ram_we;
  logic [ADR_W-1:0]             ram_waddr;
  logic [BIT_WIDTH-1:0]         ram_wdata;
  logic [ADR_W-1:0]             ram_raddr;
  logic [BIT_WIDTH-1:0]         oldest;

  logic signed [SUM_W:0]        rnd_sum;
  logic signed [SUM_W:0]        shifted;
  logic [BIT_WIDTH-1:0]         avg;

  // Tap address is {channel, pointer}; linear clear count covers the same space.
  always_comb begin
    ram_raddr = {ch_q, ptr_q[ch_q]};
    ram_we    = (state_q == StClear) || (state_q == StCalc);
    ram_waddr = (state_q == StClear) ? clr_cnt_q : ram_raddr;
    ram_wdata = (state_q == StClear) ? '0 : data_in0_q;
  end

  mavg_tap_ram #(
    .WIDTH (BIT_WIDTH),
    .ADR_W (ADR_W),
    .DEPTH (DEPTH)
  ) u_tap_ram (
    .CLK     (CLK),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (ram_raddr),
    .rd_data (oldest)
  );

  // One extra bit of headroom so rounding a full-scale positive sum can be clipped.
  always_comb begin
    rnd_sum = (SUM_W + 1)'(sum_q[ch_q]) + RND;
    shifted = rnd_sum >>> LOG2_LEN;
    avg     = (shifted > MAX_POS) ? BIT_WIDTH'(MAX_POS) : shifted[BIT_WIDTH-1:0];
  end

  always_comb begin
    FILLED = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) FILLED[c] = (fill_q[c] == FILL_W'(LENGTH));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      ch_q       <= '0;
      data_in0_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        sum_q[c]  <= '0;
        ptr_q[c]  <= '0;
        fill_q[c] <= '0;
      end
      data_out_q <= {uint_io, {(BIT_WIDTH - 1){1'b0}}};
      ch_out_q   <= '0;
      valid_q    <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StClear: begin
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            sum_q[c]  <= '0;
            ptr_q[c]  <= '0;
            fill_q[c] <= '0;
          end
          clr_cnt_q <= clr_cnt_q + ADR_W'(1);
          if (clr_cnt_q == ADR_W'(DEPTH - 1)) begin
            state_q <= StIdle;
            rdy_q   <= 1'b1;
          end
        end
        StIdle: begin
          if (CLR_FLAG) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            rdy_q     <= 1'b0;
          end else if (START_FLAG && (32'(CH_IN) < NUM_CH)) begin
            ch_q       <= CH_IN;
            data_in0_q <= {uint_io ^ DATA_IN[BIT_WIDTH-1], DATA_IN[BIT_WIDTH-2:0]};
            state_q    <= StRead;
            rdy_q      <= 1'b0;
          end
        end
        StRead: state_q <= StCalc;
        StCalc: begin
          sum_q[ch_q] <= sum_q[ch_q] + SUM_W'(data_in0_q) - SUM_W'($signed(oldest));
          ptr_q[ch_q] <= ptr_q[ch_q] + LOG2_LEN'(1);
          if (fill_q[ch_q] != FILL_W'(LENGTH)) fill_q[ch_q] <= fill_q[ch_q] + FILL_W'(1);
          state_q <= StOut;
        end
        StOut: begin
          data_out_q <= {uint_io ^ avg[BIT_WIDTH-1], avg[BIT_WIDTH-2:0]};
          ch_out_q   <= ch_q;
          valid_q    <= 1'b1;
          rdy_q      <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign DATA_OUT   = data_out_q;
  assign CH_OUT     = ch_out_q;
  assign DATA_VALID = valid_q;
  assign FILT_RDY   = rdy_q;

endmodule

// File: tb/tb_filter_mavg_multich.sv
// Directed bench: signed 4-channel instance and an offset-binary 3-channel instance, scoreboarded.
module tb_filter_mavg_multich;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] data;
    logic [3:0]  filled;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        s_start, s_clr, s_valid, s_rdy;
  logic [1:0]  s_ch, s_chout;
  logic [15:0] s_din, s_dout;
  logic [3:0]  s_filled;
  logic        u_start, u_clr, u_valid, u_rdy;
  logic [1:0]  u_ch, u_chout;
  logic [15:0] u_din, u_dout;
  logic [2:0]  u_filled;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   hist [2][4][16];
  int   mptr [2][4];
  int   mfill [2][4];

  always #5 CLK = ~CLK;

  filter_mavg_multich #(
    .BIT_WIDTH (16), .LOG2_LEN (4), .NUM_CH (4), .uint_io (1'b0), .ROUND (1'b0)
  ) dut_s (
    .CLK (CLK), .nRST (nRST), .START_FLAG (s_start), .CH_IN (s_ch), .DATA_IN (s_din),
    .CLR_FLAG (s_clr), .DATA_OUT (s_dout), .CH_OUT (s_chout), .DATA_VALID (s_valid),
    .FILT_RDY (s_rdy), .FILLED (s_filled)
  );

  filter_mavg_multich #(
    .BIT_WIDTH (16), .LOG2_LEN (4), .NUM_CH (3), .uint_io (1'b1), .ROUND (1'b0)
  ) dut_u (
    .CLK (CLK), .nRST (nRST), .START_FLAG (u_start), .CH_IN (u_ch), .DATA_IN (u_din),
    .CLR_FLAG (u_clr), .DATA_OUT (u_dout), .CH_OUT (u_chout), .DATA_VALID (u_valid),
    .FILT_RDY (u_rdy), .FILLED (u_filled)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rd_rdy(input bit u);
    return u ? u_rdy : s_rdy;
  endfunction

  function automatic logic rd_valid(input bit u);
    return u ? u_valid : s_valid;
  endfunction

  task automatic drive(input bit u, input logic st, input logic [1:0] ch, input logic [15:0] d,
                       input logic clr);
    if (u) begin
      u_start = st; u_ch = ch; u_din = d; u_clr = clr;
    end else begin
      s_start = st; s_ch = ch; s_din = d; s_clr = clr;
    end
  endtask

  task automatic model_clear(input bit u);
    for (int c = 0; c < 4; c++) begin
      mptr[u][c]  = 0;
      mfill[u][c] = 0;
      for (int i = 0; i < 16; i++) hist[u][c][i] = 0;
    end
  endtask

  // Reference: explicit 16-tap window sum, floor divide by 16.
  task automatic model_push(input bit u, input logic [1:0] ch, input logic [15:0] d,
                            output exp_t e);
    int sum;
    logic [15:0] a;
    hist[u][ch][mptr[u][ch]] = u ? int'($signed(d ^ 16'h8000)) : int'($signed(d));
    mptr[u][ch] = (mptr[u][ch] + 1) % 16;
    if (mfill[u][ch] < 16) mfill[u][ch]++;
    sum = 0;
    for (int i = 0; i < 16; i++) sum += hist[u][ch][i];
    a = 16'(sum >>> 4);
    e.data = u ? (a ^ 16'h8000) : a;
    e.ch   = ch;
    for (int c = 0; c < 4; c++) e.filled[c] = (mfill[u][c] == 16);
  endtask

  task automatic wait_rdy(input bit u);
    int n = 0;
    @(negedge CLK);
    while (!rd_rdy(u) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!rd_rdy(u)) chk("rdy_timeout", {31'b0, rd_rdy(u)}, 1);
  endtask

  // Watch for a number of cycles: count DATA_VALID pulses and note first cycle FILT_RDY is high.
  task automatic watch(input bit u, input int cycles, output int pulses, output int first_rdy);
    pulses = 0;
    first_rdy = 0;
    for (int n = 1; n <= cycles; n++) begin
      @(posedge CLK); #1;
      if (rd_valid(u)) pulses++;
      if (rd_rdy(u) && first_rdy == 0) first_rdy = n;
    end
  endtask

  // hold > 0 keeps START (and CLR) asserted with other data while the filter is busy.
  task automatic send(input bit u, input logic [1:0] ch, input logic [15:0] d, input int hold);
    exp_t e, got;
    int pulses, lat;
    logic r2, r3;
    logic [15:0] o_data;
    logic [1:0] o_ch;
    logic [3:0] o_fill;
    wait_rdy(u);
    drive(u, 1'b1, ch, d, 1'b0);
    @(posedge CLK); #1;
    if (hold == 0) drive(u, 1'b0, ch, d, 1'b0);
    else drive(u, 1'b1, ch, ~d, 1'b1);
    model_push(u, ch, d, e);
    sb.push_back(e);
    pulses = 0; lat = 0; r2 = 1'b1; r3 = 1'b0;
    o_data = '0; o_ch = '0; o_fill = '0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge CLK); #1;
      if (n == hold) drive(u, 1'b0, ch, d, 1'b0);
      if (n == 2) r2 = rd_rdy(u);
      if (n == 3) r3 = rd_rdy(u);
      if (rd_valid(u)) begin
        pulses++;
        if (lat == 0) begin
          lat    = n;
          o_data = u ? u_dout : s_dout;
          o_ch   = u ? u_chout : s_chout;
          o_fill = u ? {1'b0, u_filled} : s_filled;
        end
      end
    end
    got = sb.pop_front();
    chk("latency", lat, 3);
    chk("valid_pulses", pulses, 1);
    chk("rdy_busy", {31'b0, r2}, 0);
    chk("rdy_back", {31'b0, r3}, 1);
    chk("data_out", o_data, got.data);
    chk("ch_out", o_ch, got.ch);
    chk("filled", o_fill, got.filled);
  endtask

  initial begin
    int p, f;
    nRST = 1'b0;
    drive(0, 1'b0, 2'd0, 16'h0, 1'b0);
    drive(1, 1'b0, 2'd0, 16'h0, 1'b0);
    model_clear(0);
    model_clear(1);

    // Reset defaults and CLEAR duration
    repeat (3) @(negedge CLK);
    chk("rst_rdy", {31'b0, s_rdy}, 0);
    chk("rst_valid", {31'b0, s_valid}, 0);
    chk("rst_dout_s", s_dout, 16'h0000);
    chk("rst_dout_u", u_dout, 16'h8000);
    chk("rst_filled_s", s_filled, 0);
    chk("rst_filled_u", u_filled, 0);
    nRST = 1'b1;
    watch(0, 80, p, f);
    chk("rst_clear_cycles", f, 64);
    chk("rst_no_valid", p, 0);
    chk("rst_rdy_u", {31'b0, u_rdy}, 1);

    // Step response on ch0
    for (int k = 0; k < 16; k++) send(0, 2'd0, 16'd1000, 0);

    // CLR and START together: CLR wins, full 64-clock clear, no output
    wait_rdy(0);
    drive(0, 1'b1, 2'd1, 16'd5, 1'b1);
    @(posedge CLK); #1;
    drive(0, 1'b0, 2'd0, 16'd0, 1'b0);
    watch(0, 70, p, f);
    chk("clr_cycles", f, 64);
    chk("clr_no_valid", p, 0);
    chk("clr_filled", s_filled, 0);
    model_clear(0);

    // Channel isolation
    for (int k = 0; k < 16; k++) begin
      send(0, 2'd0, 16'd1600, 0);
      send(0, 2'd1, -16'sd1600, 0);
    end
    chk("iso_filled_hi", s_filled[3:2], 0);

    // Wrap and drift on ch2
    for (int k = 0; k < 20; k++) send(0, 2'd2, 16'd32767, 0);
    for (int k = 0; k < 16; k++) send(0, 2'd2, 16'd0, 0);
    chk("wrap_sum", 32'(dut_s.sum_q[2]), 0);
    chk("wrap_out", s_dout, 16'd0);

    // Offset-binary instance
    for (int k = 0; k < 16; k++) send(1, 2'd0, 16'hFFFF, 0);
    chk("uint_full", u_dout, 16'hFFFF);
    for (int k = 0; k < 16; k++) send(1, 2'd0, 16'h0000, 0);
    chk("uint_zero", u_dout, 16'h0000);
    for (int k = 0; k < 16; k++) send(1, 2'd0, 16'h8000, 0);
    chk("uint_mid", u_dout, 16'h8000);

    // START/CLR while busy ignored; the following sample proves no extra tap was taken
    send(0, 2'd3, 16'd320, 2);
    send(0, 2'd3, 16'd160, 0);

    // Out-of-range channel dropped
    wait_rdy(1);
    drive(1, 1'b1, 2'd3, 16'h1234, 1'b0);
    @(posedge CLK); #1;
    drive(1, 1'b0, 2'd0, 16'h0, 1'b0);
    watch(1, 6, p, f);
    chk("drop_no_valid", p, 0);
    chk("drop_rdy", f, 1);
    send(1, 2'd2, 16'h9000, 0);

    // Reset pulse during CALC
    wait_rdy(0);
    drive(0, 1'b1, 2'd0, 16'd4000, 1'b0);
    @(posedge CLK); #1;
    drive(0, 1'b0, 2'd0, 16'd0, 1'b0);
    @(posedge CLK); #1;
    chk("calc_state", 32'(dut_s.state_q), 32'(3));
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    watch(0, 80, p, f);
    chk("rst2_no_valid", p, 0);
    chk("rst2_clear_cycles", f, 64);
    chk("rst2_filled", s_filled, 0);
    chk("rst2_dout", s_dout, 16'h0000);
    model_clear(0);
    model_clear(1);
    send(0, 2'd0, 16'd1600, 0);
    send(1, 2'd1, 16'hFFFF, 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
